// File: rtl/rr_log_arbiter_if.sv
// rtl/rr_log_arbiter_if.sv - source/sink handshake bundle for the round-robin log arbiter
interface rr_log_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int PKT_WIDTH = 64
);
    localparam int ID_WIDTH = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]           in_valid;
    logic [NUM_SRC-1:0]           in_ready;
    logic [NUM_SRC*PKT_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [ID_WIDTH+PKT_WIDTH-1:0] out_data;

    // Sources and sink side: presents packets and accepts the merged stream
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rr_log_arbiter.sv
// rtl/rr_log_arbiter.sv - round-robin arbiter merging recorder log sources into one tagged stream
module rr_log_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int PKT_WIDTH = 64,
    localparam int ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rec_en,
    input  logic               cnt_clr,
    rr_log_arbiter_if.slave    bus,
    output logic               busy,
    output logic [31:0]        pkt_cnt
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One extra bit so rr_ptr + offset never overflows before the modulo fold
    localparam int               CW        = ID_WIDTH + 1;
    localparam logic [CW-1:0]    NUM_SRC_W = CW'(NUM_SRC);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SRC - 1);

    logic [1:0]                    state;
    logic [1:0]                    state_nxt;
    logic [ID_WIDTH-1:0]           rr_ptr;
    logic                          out_valid_q;
    logic [ID_WIDTH+PKT_WIDTH-1:0] out_data_q;
    logic [31:0]                   pkt_cnt_q;

    logic                          load;
    logic                          xfer;
    logic                          grant_found;
    logic [ID_WIDTH-1:0]           grant_idx;
    logic [CW-1:0]                 cand;
    logic [PKT_WIDTH-1:0]          sel_data;
    logic [NUM_SRC-1:0]            in_ready_c;

    // The output stage can take a new packet when empty or emptying this cycle
    assign load = (state == ST_RUN) && rec_en && (!out_valid_q || bus.out_ready);
    assign xfer = load && grant_found;

    // First valid source scanning upward from rr_ptr, wrapping at NUM_SRC
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= NUM_SRC_W) begin
                cand = cand - NUM_SRC_W;
            end
            if (!grant_found && bus.in_valid[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    // Select the granted packet and form the one-hot accept
    always_comb begin
        sel_data   = '0;
        in_ready_c = '0;
        for (int g = 0; g < NUM_SRC; g++) begin
            if (grant_idx == ID_WIDTH'(g)) begin
                sel_data      = bus.in_data[g*PKT_WIDTH +: PKT_WIDTH];
                in_ready_c[g] = xfer;
            end
        end
    end

    // Record-enable controller; re-enable while draining wins over going idle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rec_en) state_nxt = ST_RUN;
            ST_RUN:   if (!rec_en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (rec_en) begin
                    state_nxt = ST_RUN;
                end else if (!out_valid_q || bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output stage and round-robin pointer; a held packet is never overwritten
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {grant_idx, sel_data};
            rr_ptr      <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accepted-packet counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_q <= '0;
        end else if (cnt_clr) begin
            pkt_cnt_q <= '0;
        end else if (xfer) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state == ST_RUN) || (state == ST_DRAIN);
    assign pkt_cnt       = pkt_cnt_q;
endmodule
